// File: rtl/mdu_ctrl_if.sv
// Multiply/divide request and result bundle between the EX stage and mdu_ctrl.
// Ports: start_i/op_i/opdata1_i/opdata2_i/flush_i (request side, driven by EX),
//        stall_o/hilo_we_o/hilo_wdata_o/busy_o (status and HI/LO write, driven by the MDU).
interface mdu_ctrl_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        flush_i;
  logic        stall_o;
  logic        hilo_we_o;
  logic [63:0] hilo_wdata_o;
  logic        busy_o;

  // EX-stage side
  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, flush_i,
    input  stall_o, hilo_we_o, hilo_wdata_o, busy_o
  );

  // Sequencer side
  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, flush_i,
    output stall_o, hilo_we_o, hilo_wdata_o, busy_o
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer; issues one 64-bit HI/LO write per operation.
// Latency from accept: multiply 2 cycles, divide 33 cycles, divide-by-zero 1 cycle.
// Ports: clk, rst (sync, active-high), mdu (slave side of mdu_ctrl_if); stall_o holds EX while busy.
module mdu_ctrl (
  input logic       clk,
  input logic       rst,
  mdu_ctrl_if.slave mdu
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic        mul_signed_q;   // MULT vs MULTU
  logic        quot_neg_q;     // signed divide: quotient must be negated
  logic        rem_neg_q;      // signed divide: remainder must be negated
  logic [31:0] a_q;            // multiplicand, or dividend shifting into quotient
  logic [31:0] b_q;            // multiplier, or divisor magnitude
  logic [31:0] rem_q;          // partial remainder (always < divisor, so 32 bits hold it)
  logic        we_q;
  logic        busy_q;
  logic [63:0] hilo_q;

  logic        accept;
  logic        req_div;
  logic        req_signed;
  logic        stall;

  // Multiply: the 33x33 signed product of the extended operands; only the low
  // 64 bits are ever needed, so the operands are extended straight to 64 bits.
  logic        ext_a;
  logic        ext_b;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  // One restoring divide step.
  logic [32:0] r_shift;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign req_div    = mdu.op_i[1];
  assign req_signed = ~mdu.op_i[0];
  assign accept     = (state == IDLE) & mdu.start_i & ~mdu.flush_i;

  assign ext_a = mul_signed_q & a_q[31];
  assign ext_b = mul_signed_q & b_q[31];
  assign mul_a = {{32{ext_a}}, a_q};
  assign mul_b = {{32{ext_b}}, b_q};
  assign prod  = mul_a * mul_b;

  assign r_shift  = {rem_q, a_q[31]};
  assign diff     = r_shift - {1'b0, b_q};
  assign qbit     = ~diff[32];                  // no borrow: divisor fits
  assign rem_step = qbit ? diff[31:0] : r_shift[31:0];
  assign quo_step = {a_q[30:0], qbit};
  assign quo_fix  = quot_neg_q ? (32'd0 - quo_step) : quo_step;
  assign rem_fix  = rem_neg_q  ? (32'd0 - rem_step) : rem_step;

  // Next-state and stall request
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall = 1'b1;
          if (!req_div)                  state_nxt = MUL;
          else if (mdu.opdata2_i == '0)  state_nxt = DONE;
          else                           state_nxt = DIV;
        end
      end
      MUL: begin
        stall     = 1'b1;
        state_nxt = DONE;
      end
      DIV: begin
        stall = 1'b1;
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DONE: begin
        // start_i here still belongs to the departing instruction
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (mdu.flush_i) begin
      state_nxt = IDLE;
      stall     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mul_signed_q <= 1'b0;
      quot_neg_q   <= 1'b0;
      rem_neg_q    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rem_q        <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      hilo_q       <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      we_q   <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            mul_signed_q <= req_signed;
            quot_neg_q   <= req_div & req_signed & (mdu.opdata1_i[31] ^ mdu.opdata2_i[31]);
            rem_neg_q    <= req_div & req_signed & mdu.opdata1_i[31];
            rem_q        <= '0;
            cnt          <= '0;
            if (req_div && req_signed) begin
              a_q <= mdu.opdata1_i[31] ? (32'd0 - mdu.opdata1_i) : mdu.opdata1_i;
              b_q <= mdu.opdata2_i[31] ? (32'd0 - mdu.opdata2_i) : mdu.opdata2_i;
            end else begin
              a_q <= mdu.opdata1_i;
              b_q <= mdu.opdata2_i;
            end
            if (req_div && (mdu.opdata2_i == '0))
              hilo_q <= {mdu.opdata1_i, 32'hFFFF_FFFF};
          end
        end
        MUL: begin
          if (!mdu.flush_i) hilo_q <= prod;
        end
        DIV: begin
          if (!mdu.flush_i) begin
            a_q   <= quo_step;
            rem_q <= rem_step;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) hilo_q <= {rem_fix, quo_fix};
          end
        end
        default: ;
      endcase
    end
  end

  assign mdu.stall_o      = stall;
  assign mdu.hilo_we_o    = we_q;
  assign mdu.hilo_wdata_o = hilo_q;
  assign mdu.busy_o       = busy_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus 1000 randomized operations.
// Expected HI/LO values are queued when an operation is launched and popped on each write strobe.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic rst;

  mdu_ctrl_if mif ();

  mdu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .mdu (mif)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model for the HI/LO result
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64;
    logic signed [31:0] qs, rs;
    case (op)
      2'b00: begin
        sa   = 64'($signed(a));
        sb64 = 64'($signed(b));
        return sa * sb64;
      end
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qs = $signed(a) / $signed(b);
        rs = $signed(a) % $signed(b);
        return {rs, qs};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Scoreboard: every write strobe must match the oldest expected result
  always @(negedge clk) begin
    if (mif.hilo_we_o) begin
      if (sb.size() == 0) chk("unexpected_we", 64'd1, 64'd0);
      else chk("hilo_result", mif.hilo_wdata_o, sb.pop_front());
    end
  end

  // Launch one operation at the current (post-edge) cycle T. flush_at<0 means
  // no flush; otherwise flush_i is raised in cycle T+flush_at. start_i is held
  // until the operation leaves EX, including the DONE cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int flush_at);
    int lat, stalls, we_at;
    bit cancelled, finished;
    logic [63:0] saved;
    lat       = (op[1] == 1'b0) ? 2 : ((b == 0) ? 1 : 33);
    saved     = mif.hilo_wdata_o;
    stalls    = 0;
    we_at     = -1;
    cancelled = 1'b0;
    finished  = 1'b0;
    if (flush_at < 0) sb.push_back(exp);
    mif.start_i   = 1'b1;
    mif.op_i      = op;
    mif.opdata1_i = a;
    mif.opdata2_i = b;
    for (int k = 0; k < lat + 4; k++) begin
      if (!cancelled && !finished) begin
        mif.flush_i = (k == flush_at);
        @(negedge clk);
        if (mif.stall_o) stalls++;
        if (mif.hilo_we_o && we_at < 0) we_at = k;
        if (k == flush_at) chk({tag, "_flush_stall"}, 64'(mif.stall_o), 64'd0);
        @(posedge clk); #1;
        if (k == flush_at) begin
          cancelled   = 1'b1;
          mif.start_i = 1'b0;
          mif.flush_i = 1'b0;
        end else if (we_at >= 0) begin
          finished    = 1'b1;
          mif.start_i = 1'b0;
        end
      end
    end
    mif.start_i = 1'b0;
    mif.flush_i = 1'b0;
    if (cancelled) begin
      @(negedge clk);
      chk({tag, "_flush_busy"}, 64'(mif.busy_o), 64'd0);
      chk({tag, "_flush_we"}, 64'(mif.hilo_we_o), 64'd0);
      chk({tag, "_flush_wdata"}, mif.hilo_wdata_o, saved);
      @(posedge clk); #1;
    end else begin
      chk({tag, "_stall_cycles"}, 64'(stalls), 64'(lat));
      chk({tag, "_we_latency"}, 64'(we_at), 64'(lat));
    end
  endtask

  // After an operation with start_i held through DONE, the unit must be idle
  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(mif.busy_o), 64'd0);
    chk({tag, "_idle_stall"}, 64'(mif.stall_o), 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          lat, fa;

    rst           = 1'b1;
    mif.start_i   = 1'b0;
    mif.op_i      = 2'b00;
    mif.opdata1_i = '0;
    mif.opdata2_i = '0;
    mif.flush_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(mif.busy_o), 64'd0);
    chk("reset_we", 64'(mif.hilo_we_o), 64'd0);
    chk("reset_stall", 64'(mif.stall_o), 64'd0);
    chk("reset_wdata", mif.hilo_wdata_o, 64'd0);
    @(posedge clk); #1;

    run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, -1);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
    idle_check("multu_max");
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, -1);
    idle_check("divu_100_7");
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, -1);
    run_op("divu_by0", 2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, -1);
    idle_check("divu_by0");
    // Divide iteration cnt==10 happens in cycle T+11
    run_op("div_flush", 2'b10, 32'd1000, 32'd3, 64'd0, 11);
    run_op("mult_2x3", 2'b00, 32'd2, 32'd3, 64'd6, -1);

    // Reset in the MUL cycle (T+1) of a multiply
    mif.start_i   = 1'b1;
    mif.op_i      = 2'b00;
    mif.opdata1_i = 32'd7;
    mif.opdata2_i = 32'd9;
    @(posedge clk); #1;
    mif.start_i = 1'b0;
    rst         = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(mif.busy_o), 64'd0);
    chk("rst_mid_we", 64'(mif.hilo_we_o), 64'd0);
    chk("rst_mid_stall", 64'(mif.stall_o), 64'd0);
    chk("rst_mid_wdata", mif.hilo_wdata_o, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = pick_operand();
      b   = pick_operand();
      lat = (op[1] == 1'b0) ? 2 : ((b == 0) ? 1 : 33);
      fa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
      run_op("rand", op, a, b, model(op, a, b), fa);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer in the EX stage, alongside the single-cycle ALU. It accepts MULT/MULTU/DIV/DIVU requests from the EX stage and latches their operands. It runs a 2-cycle multiply or a 32-iteration restoring divide, and holds the pipeline with a stall request while busy. On completion it issues a single one-cycle 64-bit write to the HI/LO register; MFHI/MFLO reads in the ALU then see the result.

## Interface
- No parameters; data width is fixed at 32 bits, and the result is 64 bits.
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  the EX-stage instruction is a multiply or divide; sampled only in IDLE.
- op_i  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opdata1_i  input  32  rs value (multiplicand or dividend).
- opdata2_i  input  32  rt value (multiplier or divisor).
- flush_i  input  1  pipeline flush (exception or ERET); cancels any operation.
- stall_o  output  1  EX stall request.
- hilo_we_o  output  1  HI/LO write strobe, one cycle wide.
- hilo_wdata_o  output  64  {HI, LO} result; registered; holds its last value.
- busy_o  output  1  FSM is not in IDLE.

## Operation
- States:
  - IDLE: waiting for a request.
  - MUL: one compute cycle.
  - DIV: 32 iterations, counter cnt[4:0].
  - DONE: one writeback cycle.
- IDLE:
  - If start_i & ~flush_i, latch op_i and both operands.
  - Multiply goes to MUL.
  - Divide with opdata2_i==0 goes directly to DONE.
  - Other divides go to DIV, with cnt=0.
- Multiply:
  - In MUL, compute the 64-bit product into the result register, then go to DONE.
  - MULT is a signed 32x32 multiply; MULTU is unsigned.
  - Implement both as a 33x33 signed multiply, with operands sign- or zero-extended.
- Divide setup:
  - For DIV, take the absolute values of both operands.
  - Record the sign of the quotient as (a[31]^b[31]) and the sign of the remainder as a[31].
  - For DIVU, use the raw operands.
- Divide iteration:
  - Each DIV cycle performs one restoring step on a 33-bit partial remainder and shifts one quotient bit in, MSB first.
  - After the step with cnt==31, go to DONE.
- Divide fix-up, applied when entering DONE:
  - For signed divides, negate the quotient if its sign is set, and negate the remainder if the dividend was negative.
  - Result: HI=remainder, LO=quotient.
- Divide by zero: result is {HI, LO} = {opdata1_i, 32'hFFFFFFFF} for both DIV and DIVU.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. There is no trap.
- DONE:
  - hilo_we_o=1 and stall_o=0, so the instruction leaves EX.
  - start_i is ignored in DONE, because it still reflects the departing instruction.
  - Next state is IDLE.
- stall_o = (state==IDLE & start_i & ~flush_i) | state==MUL | state==DIV. This is the only combinational output.
- Flush:
  - flush_i forces the next state to IDLE from any state.
  - While flush_i is high, stall_o and hilo_we_o are both 0.
  - No HI/LO write occurs for the cancelled operation.
  - hilo_wdata_o is not updated.
- Reset:
  - state=IDLE and cnt=0.
  - hilo_we_o=0, busy_o=0, hilo_wdata_o=64'h0, and all internal operand and result registers are 0.
  - rst takes priority over flush_i and start_i.
  - Reset mid-operation aborts the operation without a write.

## Timing
- All latencies are counted from cycle T, the IDLE cycle in which start_i is accepted.
- Multiply:
  - stall_o is high in T and T+1.
  - DONE occurs at T+2, with hilo_we_o=1 and valid data.
- Divide, normal:
  - stall_o is high in T through T+32 (33 cycles).
  - DONE occurs at T+33.
- Divide by zero:
  - stall_o is high in T only.
  - DONE occurs at T+1.
- Back-to-back requests: the earliest new start is the cycle after DONE.
- hilo_we_o is registered, and hilo_wdata_o is stable whenever hilo_we_o=1.
- busy_o is registered and equals (state!=IDLE).

## Test plan
- MULT -3 × 5, then MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - First result: hilo_we_o at T+2 with {HI, LO} = 0xFFFFFFFF_FFFFFFF1.
  - Second result: 0xFFFFFFFE_00000001.
  - stall_o is high for exactly 2 cycles each time.
- DIV -7 / 2 and DIVU 100 / 7:
  - First result: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Second result: LO=14, HI=2.
  - In both cases, we at T+33 after 33 stall cycles.
- Corner divides: DIV 0x80000000 / 0xFFFFFFFF, then DIVU 5 / 0:
  - First result: LO=0x80000000, HI=0.
  - Second result: HI=5, LO=0xFFFFFFFF, with we at T+1.
- flush_i asserted at divide iteration cnt==10:
  - Next cycle is IDLE, with no hilo_we_o pulse.
  - hilo_wdata_o is unchanged.
  - A following MULT 2 × 3 completes normally with {HI, LO} = 0x0_6.
- rst asserted at multiply T+1:
  - All outputs are 0 on the next cycle, with no write.
  - A start_i held high during DONE of a prior operation does not launch a second operation.
- Randomized 1000 operations against a reference model:
  - Covers all 4 ops with random flushes.
  - Checks result values, stall_o cycle counts, and exactly one hilo_we_o per uncancelled operation.
